muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 14 +
 rtl/muldiv_if.sv | 18 +
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: RV M-extension
// op encodings and the FSM state type.
package muldiv_pkg;
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/muldiv_if.sv
// Request/result handshake bundle between a requester (master) and the
// multiply/divide unit (slave).
interface muldiv_if #(parameter int XLEN = 64);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            busy;

  modport master (output in_valid, in_op, in_a, in_b, out_ready,
                  input  in_ready, out_valid, out_result, busy);
  modport slave  (input  in_valid, in_op, in_a, in_b, out_ready,
                  output in_ready, out_valid, out_result, busy);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply, restoring divide.
// Divider datapath and ops 4..7 are compiled in only with MULDIV_DIV_EN.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic en);
    return en ? (~x) + XLEN'(1) : x;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] x, input logic en);
    return en ? (~x) + (2*XLEN)'(1) : x;
  endfunction

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod;
`ifdef MULDIV_DIV_EN
  logic [XLEN:0]     div_sh, div_diff;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    mul_sum = '0;
    prod    = '0;
`ifdef MULDIV_DIV_EN
    div_sh   = '0;
    div_diff = '0;
`endif
    a_signed = (bus.in_op == OP_MULH) || (bus.in_op == OP_MULHSU) ||
               (bus.in_op == OP_DIV)  || (bus.in_op == OP_REM);
    b_signed = (bus.in_op == OP_MULH) || (bus.in_op == OP_DIV) || (bus.in_op == OP_REM);
    a_neg    = a_signed && bus.in_a[XLEN-1];
    b_neg    = b_signed && bus.in_b[XLEN-1];

    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        op_d  = bus.in_op;
        // remainder follows the dividend; everything else is sign(a)^sign(b)
        neg_d = (bus.in_op == OP_REM) ? a_neg : (a_neg ^ b_neg);
        cnt_d = CW'(XLEN);
        if (!bus.in_op[2]) begin
          mcand_d = cond_neg(bus.in_a, a_neg);
          acc_d   = {{XLEN{1'b0}}, cond_neg(bus.in_b, b_neg)};
          state_d = CALC;
        end else begin
`ifdef MULDIV_DIV_EN
          if (bus.in_b == '0) begin
            res_d   = bus.in_op[1] ? bus.in_a : '1;
            cnt_d   = '0;
            state_d = DONE;
          end else if (!bus.in_op[0] && bus.in_a == MIN_NEG && bus.in_b == '1) begin
            res_d   = bus.in_op[1] ? '0 : bus.in_a;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            mcand_d = cond_neg(bus.in_b, b_neg);
            acc_d   = {{XLEN{1'b0}}, cond_neg(bus.in_a, a_neg)};
            state_d = CALC;
          end
`else
          res_d   = '0;
          cnt_d   = '0;
          state_d = DONE;
`endif
        end
      end
      CALC: begin
        cnt_d = cnt_q - CW'(1);
`ifdef MULDIV_DIV_EN
        if (op_q[2]) begin
          // acc = {remainder, dividend->quotient}
          div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
          div_diff = div_sh - {1'b0, mcand_q};
          if (!div_diff[XLEN]) acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else                 acc_d = {div_sh[XLEN-1:0],   acc_q[XLEN-2:0], 1'b0};
        end else
`endif
        begin
          mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
          acc_d   = {mul_sum, acc_q[XLEN-1:1]};
        end
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          if (!op_q[2]) begin
            prod  = cond_neg2(acc_d, neg_q);
            res_d = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          end
`ifdef MULDIV_DIV_EN
          else if (op_q[1]) res_d = cond_neg(acc_d[2*XLEN-1:XLEN], neg_q);
          else              res_d = cond_neg(acc_d[XLEN-1:0], neg_q);
`endif
        end
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.out_result = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized bench for muldiv_unit (XLEN=64) against a plain
// arithmetic reference model; honours MULDIV_DIV_EN like the design.
module tb_muldiv_unit;
  localparam int XLEN = 64;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk, rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  muldiv_if #(.XLEN(XLEN)) bus();
  muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, ua, ub, p;
    sa = $signed({{64{a[63]}}, a});
    sb = $signed({{64{b[63]}}, b});
    ua = $signed({64'd0, a});
    ub = $signed({64'd0, b});
    case (op)
      3'd0: begin p = ua * ub; return p[63:0]; end
      3'd1: begin p = sa * sb; return p[127:64]; end
      3'd2: begin p = sa * ub; return p[127:64]; end
      3'd3: begin p = ua * ub; return p[127:64]; end
`ifdef MULDIV_DIV_EN
      3'd4: if (b == 0) return ONES;
            else if (a == MINV && b == ONES) return a;
            else return $signed(a) / $signed(b);
      3'd5: return (b == 0) ? ONES : a / b;
      3'd6: if (b == 0) return a;
            else if (a == MINV && b == ONES) return 64'd0;
            else return $signed(a) % $signed(b);
      3'd7: return (b == 0) ? a : a % b;
`endif
      default: return 64'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op < 3'd4) return XLEN + 1;
`ifdef MULDIV_DIV_EN
    if (b == 0 || (!op[0] && a == MINV && b == ONES)) return 1;
    return XLEN + 1;
`else
    return 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input int hold, input string tag);
    logic [63:0] exp_r;
    int exp_lat, lat;
    exp_r   = ref_res(op, a, b);
    exp_lat = ref_lat(op, a, b);
    check({tag, " in_ready idle"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
    @(posedge clk); #1;
    // scribble on the inputs while the op runs
    bus.in_valid = 1'b0;
    bus.in_op = 3'($urandom);
    bus.in_a  = {$urandom, $urandom};
    bus.in_b  = {$urandom, $urandom};
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, bus.out_result, exp_r);
    repeat (hold) begin
      @(posedge clk); #1;
      check({tag, " held result"}, bus.out_result, exp_r);
      check({tag, " in_ready in DONE"}, 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, " in_ready after retire"}, 64'(bus.in_ready), 64'd1);
    check({tag, " out_valid after retire"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [63:0] a, b;
    logic        seen;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset out_result", bus.out_result, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(3'd0, 64'd7, -64'sd3, 0, "MUL 7*-3");
    do_op(3'd3, ONES, 64'd2, 1, "MULHU");
    do_op(3'd1, ONES, ONES, 0, "MULH -1*-1");
    do_op(3'd2, -64'sd5, ONES, 0, "MULHSU");
    do_op(3'd4, -64'sd7, 64'd2, 0, "DIV -7/2");
    do_op(3'd6, -64'sd7, 64'd2, 0, "REM -7/2");
    do_op(3'd5, 64'd100, 64'd7, 0, "DIVU 100/7");
    do_op(3'd7, 64'd100, 64'd7, 0, "REMU 100/7");
    do_op(3'd6, 64'd5, 64'd0, 0, "REM 5/0");
    do_op(3'd4, MINV, ONES, 0, "DIV ovf");
    do_op(3'd6, MINV, ONES, 0, "REM ovf");
    do_op(3'd4, 64'd5, 64'd0, 10, "DIV 5/0 hold10");
    do_op(3'd0, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 10, "MUL hold10");

    // abort mid-calculation with a reset pulse
    bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_a = 64'd9; bus.in_b = 64'd9;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    check("busy mid CALC", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #2;
    check("abort in_ready", 64'(bus.in_ready), 64'd1);
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort out_valid", 64'(bus.out_valid), 64'd0);
    check("abort out_result", bus.out_result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("abort no result", 64'(seen), 64'd0);

    for (int i = 0; i < 50; i++) begin
      op = 3'($urandom);
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0: b = 64'd0;
        1: begin a = MINV; b = ONES; end
        2: begin
          a = 64'($urandom_range(0, 200));
          b = 64'($urandom_range(1, 20));
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: ;
      endcase
      do_op(op, a, b, $urandom_range(0, 3), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
